// File: rtl/ifu_fetch_queue.sv
// Sequential instruction fetch with credit-limited in-flight requests and a {pc,inst} FIFO toward ID.
// Define IFU_BYPASS_EN to forward a response straight to ID when the queue is empty (0-cycle path).
module ifu_fetch_queue #(
  parameter int                  DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC      = 32'h8000_0000,
  parameter int                  QUEUE_DEPTH     = 4,
  parameter int                  MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   id_to_if_bus,
  input  logic                    id_to_if_valid,
  output logic                    if_to_id_ready,
  output logic [2*DATA_WIDTH-1:0] if_to_id_bus,
  output logic                    if_to_id_valid,
  input  logic                    id_to_if_ready,
  input  logic                    wb_to_if_done,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [DATA_WIDTH-1:0]   imem_req_addr,
  input  logic                    imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_resp_data
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int IFP_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int ENT_W = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] PC_INC   = DATA_WIDTH'(DATA_WIDTH / 8);
  localparam logic [CNT_W-1:0]      MO_LIM   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]        QD_LIM   = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [IFP_W-1:0]      IFP_LAST = IFP_W'(MAX_OUTSTANDING - 1);

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ENT_W-1:0]      queue_q [QUEUE_DEPTH];
  logic [ENT_W-1:0]      queue_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      out_q, out_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [DATA_WIDTH-1:0] inflight_q [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] inflight_d [MAX_OUTSTANDING];
  logic [IFP_W-1:0]      if_wr_q, if_wr_d, if_rd_q, if_rd_d;

  logic             redirect, req_hs, resp_keep, resp_drop, q_nonempty;
  logic             push, pop, bypass;
  logic [CNT_W:0]   used;
  logic [ENT_W-1:0] resp_entry;

  function automatic logic [IFP_W-1:0] if_next(input logic [IFP_W-1:0] p);
    return (p == IFP_LAST) ? '0 : p + IFP_W'(1);
  endfunction

  // Every issued request owns a queue slot, so responses never need back-pressure.
  assign used           = {1'b0, out_q} + {1'b0, count_q};
  assign if_to_id_ready = rst;
  assign redirect       = id_to_if_valid & rst;
  assign imem_req_valid = rst & wb_to_if_done & ~redirect & (out_q < MO_LIM) & (used < QD_LIM);
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid & imem_req_ready;
  assign resp_drop      = imem_resp_valid & (drop_q != '0);
  assign resp_keep      = imem_resp_valid & (drop_q == '0);
  assign resp_entry     = {inflight_q[if_rd_q], imem_resp_data};
  assign q_nonempty     = (count_q != '0);

`ifdef IFU_BYPASS_EN
  assign bypass         = rst & ~q_nonempty & resp_keep;
  assign if_to_id_valid = rst & (q_nonempty | bypass);
  assign if_to_id_bus   = ~rst ? '0 : q_nonempty ? queue_q[head_q] : bypass ? resp_entry : '0;
`else
  assign bypass         = 1'b0;
  assign if_to_id_valid = rst & q_nonempty;
  assign if_to_id_bus   = if_to_id_valid ? queue_q[head_q] : '0;
`endif

  // A redirect flushes the queue, so neither the pop nor the arriving response lands.
  assign pop  = q_nonempty & id_to_if_ready & ~redirect;
  assign push = resp_keep & ~redirect & ~(bypass & id_to_if_ready);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    queue_d    = queue_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    out_d      = out_q + CNT_W'(req_hs) - CNT_W'(imem_resp_valid);
    drop_d     = drop_q;
    inflight_d = inflight_q;
    if_wr_d    = if_wr_q;
    if_rd_d    = if_rd_q;

    if (redirect)    fetch_pc_d = id_to_if_bus;
    else if (req_hs) fetch_pc_d = fetch_pc_q + PC_INC;

    if (push) queue_d[tail_q] = resp_entry;

    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      // Whatever is still in flight after this cycle belongs to the old path.
      drop_d  = out_q - CNT_W'(imem_resp_valid);
    end else begin
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(push);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (resp_drop) drop_d = drop_q - CNT_W'(1);
    end

    if (req_hs) begin
      inflight_d[if_wr_q] = fetch_pc_q;
      if_wr_d             = if_next(if_wr_q);
    end
    if (imem_resp_valid) if_rd_d = if_next(if_rd_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      if_wr_q    <= '0;
      if_rd_q    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++)     queue_q[i]    <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) inflight_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      if_wr_q    <= if_wr_d;
      if_rd_q    <= if_rd_d;
      queue_q    <= queue_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue; memory returns ~addr as the instruction word.
// Expectations target the default build; a short 0-cycle check runs when IFU_BYPASS_EN is defined.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_to_if_bus;
  logic        id_to_if_valid;
  logic        if_to_id_ready;
  logic [63:0] if_to_id_bus;
  logic        if_to_id_valid;
  logic        id_to_if_ready;
  logic        wb_to_if_done;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pend_q[$];
  logic        mem_hold;

  ifu_fetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .id_to_if_bus    (id_to_if_bus),
    .id_to_if_valid  (id_to_if_valid),
    .if_to_id_ready  (if_to_id_ready),
    .if_to_id_bus    (if_to_id_bus),
    .if_to_id_valid  (if_to_id_valid),
    .id_to_if_ready  (id_to_if_ready),
    .wb_to_if_done   (wb_to_if_done),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ent(input logic [31:0] pc);
    return {pc, ~pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {63'd0, if_to_id_valid}, 64'd1);
    chk({tag, "_bus"}, if_to_id_bus, ent(pc));
  endtask

  // One clock: memory captures the handshake and, unless held, answers the oldest request next cycle.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    logic [31:0] d;
    hs = imem_req_valid & imem_req_ready;
    a  = imem_req_addr;
    @(posedge clk);
    #1;
    if (hs) pend_q.push_back(a);
    if (!mem_hold && pend_q.size() > 0) begin
      d = pend_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = ~d;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    id_to_if_valid  = 1'b0;
    mem_hold        = 1'b0;
    pend_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; id_to_if_bus = '0; id_to_if_valid = 1'b0; id_to_if_ready = 1'b0;
    wb_to_if_done = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0;
    imem_resp_data = '0; mem_hold = 1'b0;
    #12;
    chk("rst_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_bus", if_to_id_bus, 64'd0);
    chk("rst_ready", {63'd0, if_to_id_ready}, 64'd0);

    // Steady streaming with 1-cycle memory
    id_to_if_ready = 1'b1;
    do_reset();
    chk("t1_ready", {63'd0, if_to_id_ready}, 64'd1);
    chk("t1_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("t1_addr0", {32'd0, imem_req_addr}, {32'd0, 32'h8000_0000});
    tick();
    chk("t1_empty", {63'd0, if_to_id_valid}, 64'd0);
    chk("t1_addr1", {32'd0, imem_req_addr}, {32'd0, 32'h8000_0004});
    tick(); chk_head("t1_h0", 32'h8000_0000);
    tick(); chk_head("t1_h1", 32'h8000_0004);
    tick(); chk_head("t1_h2", 32'h8000_0008);

    // Redirect while a response arrives, a pop is requested and two requests are in flight
    mem_hold = 1'b1; id_to_if_ready = 1'b0;
    tick();
    chk_head("t4_hold_head", 32'h8000_0008);
    chk("t4_addr14", {32'd0, imem_req_addr}, {32'd0, 32'h8000_0014});
    mem_hold = 1'b0;
    tick();
    chk("t4_credit_stop", {63'd0, imem_req_valid}, 64'd0);
    id_to_if_ready = 1'b1; id_to_if_valid = 1'b1; id_to_if_bus = 32'h8000_2000;
    #1;
    chk("t4_resp_same_cycle", {63'd0, imem_resp_valid}, 64'd1);
    tick();
    id_to_if_valid = 1'b0;
    #1;
    chk("t4_flushed", {63'd0, if_to_id_valid}, 64'd0);
    chk("t4_new_req", {63'd0, imem_req_valid}, 64'd1);
    chk("t4_new_addr", {32'd0, imem_req_addr}, {32'd0, 32'h8000_2000});
    tick();
    chk("t4_stale_dropped", {63'd0, if_to_id_valid}, 64'd0);
    tick(); chk_head("t4_target", 32'h8000_2000);

    // ID stalled: fill exactly QUEUE_DEPTH, then drain with no loss or duplication
    id_to_if_ready = 1'b0;
    do_reset();
    repeat (20) tick();
    chk("t2_req_stop", {63'd0, imem_req_valid}, 64'd0);
    chk("t2_next_addr", {32'd0, imem_req_addr}, {32'd0, 32'h8000_0010});
    chk_head("t2_h0", 32'h8000_0000);
    id_to_if_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_head("t2_drain", 32'h8000_0004 + 32'(4 * i));
    end

    // Full queue then asynchronous reset between clock edges
    id_to_if_ready = 1'b0;
    repeat (10) tick();
    chk("t6_full_valid", {63'd0, if_to_id_valid}, 64'd1);
    rst = 1'b0;
    #1;
    chk("t6_async_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("t6_async_req", {63'd0, imem_req_valid}, 64'd0);
    chk("t6_async_bus", if_to_id_bus, 64'd0);
    chk("t6_async_ready", {63'd0, if_to_id_ready}, 64'd0);
    do_reset();
    chk("t6_restart_req", {63'd0, imem_req_valid}, 64'd1);
    chk("t6_restart_addr", {32'd0, imem_req_addr}, {32'd0, 32'h8000_0000});
    chk("t6_restart_empty", {63'd0, if_to_id_valid}, 64'd0);

    // Redirect with two requests outstanding and no response yet
    id_to_if_ready = 1'b1;
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    chk("t3_two_out", {63'd0, imem_req_valid}, 64'd0);
    id_to_if_valid = 1'b1; id_to_if_bus = 32'h8000_1000;
    #1;
    tick();
    id_to_if_valid = 1'b0; mem_hold = 1'b0;
    #1;
    chk("t3_flushed", {63'd0, if_to_id_valid}, 64'd0);
    chk("t3_still_out", {63'd0, imem_req_valid}, 64'd0);
    tick();
    chk("t3_drop0_valid", {63'd0, if_to_id_valid}, 64'd0);
    tick();
    chk("t3_drop1_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("t3_req_after", {63'd0, imem_req_valid}, 64'd1);
    chk("t3_req_addr", {32'd0, imem_req_addr}, {32'd0, 32'h8000_1000});
    tick();
    chk("t3_wait", {63'd0, if_to_id_valid}, 64'd0);
    tick(); chk_head("t3_target", 32'h8000_1000);
    tick(); chk_head("t3_next", 32'h8000_1004);

    // Fetch disabled while two requests are outstanding
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    wb_to_if_done = 1'b0; mem_hold = 1'b0;
    #1;
    chk("t5_no_req0", {63'd0, imem_req_valid}, 64'd0);
    tick();
    chk("t5_no_req1", {63'd0, imem_req_valid}, 64'd0);
    chk("t5_empty", {63'd0, if_to_id_valid}, 64'd0);
    tick(); chk_head("t5_h0", 32'h8000_0000);
    chk("t5_no_req2", {63'd0, imem_req_valid}, 64'd0);
    tick(); chk_head("t5_h1", 32'h8000_0004);
    tick();
    chk("t5_drained", {63'd0, if_to_id_valid}, 64'd0);
    chk("t5_no_req3", {63'd0, imem_req_valid}, 64'd0);
    wb_to_if_done = 1'b1;
    #1;
    chk("t5_resume", {63'd0, imem_req_valid}, 64'd1);
    chk("t5_resume_addr", {32'd0, imem_req_addr}, {32'd0, 32'h8000_0008});

`ifdef IFU_BYPASS_EN
    do_reset();
    tick();
    chk_head("byp_zero_latency", 32'h8000_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
